// File: rtl/fp_adder.sv
// fp_adder -- pipelined IEEE-754 binary16 adder, four register stages.
//
// Ports:
//   clk_59  in   1  clock; all state updates on its rising edge
//   rst_59  in   1  asynchronous reset, active-low; clears every pipeline
//                   register and C_59
//   A_59    in  16  operand A, binary16
//   B_59    in  16  operand B, binary16
//   C_59    out 16  registered sum A_59 + B_59; operands sampled at rising
//                   edge N appear on C_59 just after rising edge N+3
//
// One operand pair is accepted every cycle, with no handshake.
// Subnormal inputs are read as signed zero. Results that underflow flush
// to signed zero. Results that overflow saturate to signed infinity.
//
// Build option:
//   FPADD_RNE_EN  defined   -> round to nearest even (guard/round/sticky)
//                 undefined -> truncate toward zero
// Latency and ports are the same in both builds.
module fp_adder (
    input  logic        clk_59,
    input  logic        rst_59,
    input  logic [15:0] A_59,
    input  logic [15:0] B_59,
    output logic [15:0] C_59
);
    localparam int DATA_W = 16;

    // Right-shift the smaller significand into a {man, guard, round, sticky}
    // window; shifts of 12 or more leave only the sticky bit.
    function automatic logic [13:0] align_sticky(input logic [10:0] man,
                                                 input logic [4:0]  sh);
        logic [27:0] wide;
        logic [13:0] res;
        wide = {man, 17'd0} >> sh;
        if (sh >= 5'd12) begin
            res = {13'd0, |man};
        end else begin
            res = {wide[27:15], |wide[14:0]};
        end
        return res;
    endfunction

    // Leading-zero count over a 14-bit magnitude (14 when all zero).
    function automatic logic [3:0] lzc14(input logic [13:0] v);
        logic [3:0] n;
        n = 4'd14;
        for (int i = 0; i < 14; i++) begin
            if (v[i]) n = 4'(13 - i);
        end
        return n;
    endfunction

    // Rounds the normalized {1.frac, g, r, s}. Bit 11 of the result flags
    // mantissa overflow out of the hidden-bit position.
    function automatic logic [11:0] round_man(input logic [13:0] n);
        logic inc;
`ifdef FPADD_RNE_EN
        inc = n[2] & (n[1] | n[0] | n[3]);
`else
        inc = 1'b0;
`endif
        return {1'b0, n[13:3]} + {11'd0, inc};
    endfunction

    // Final renormalization after rounding, then saturation to infinity
    // or flush to signed zero.
    function automatic logic [15:0] pack_sat(input logic              s,
                                             input logic signed [6:0] e,
                                             input logic [11:0]       m);
        logic signed [6:0] ef;
        logic [9:0]        fr;
        logic [15:0]       res;
        ef = m[11] ? (e + 7'sd1) : e;
        fr = m[11] ? m[10:1] : m[9:0];
        if (ef >= 7'sd31) begin
            res = {s, 5'h1F, 10'd0};
        end else if (ef < 7'sd1) begin
            res = {s, 15'd0};
        end else begin
            res = {s, ef[4:0], fr};
        end
        return res;
    endfunction

    // ---------------- stage 1: unpack, classify, compare, swap ----------------
    logic              sa, sb;
    logic [4:0]        ea, eb;
    logic [9:0]        fa, fb;
    logic              a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic              swap;
    logic              spec_s1;
    logic [DATA_W-1:0] spec_val_s1;

    assign sa     = A_59[15];
    assign sb     = B_59[15];
    assign ea     = A_59[14:10];
    assign eb     = B_59[14:10];
    assign fa     = A_59[9:0];
    assign fb     = B_59[9:0];
    assign a_zero = (ea == 5'd0);
    assign b_zero = (eb == 5'd0);
    assign a_inf  = (ea == 5'h1F) && (fa == 10'd0);
    assign b_inf  = (eb == 5'h1F) && (fb == 10'd0);
    assign a_nan  = (ea == 5'h1F) && (fa != 10'd0);
    assign b_nan  = (eb == 5'h1F) && (fb != 10'd0);
    assign swap   = {eb, fb} > {ea, fa};

    // Results that do not need the arithmetic path are fixed here and ride
    // down the pipeline so they keep the normal latency.
    always_comb begin
        spec_s1     = 1'b0;
        spec_val_s1 = '0;
        if (a_nan || b_nan || (a_inf && b_inf && (sa != sb))) begin
            spec_s1     = 1'b1;
            spec_val_s1 = 16'h7E00;
        end else if (a_inf) begin
            spec_s1     = 1'b1;
            spec_val_s1 = {sa, 5'h1F, 10'd0};
        end else if (b_inf) begin
            spec_s1     = 1'b1;
            spec_val_s1 = {sb, 5'h1F, 10'd0};
        end else if (a_zero && b_zero) begin
            spec_s1     = 1'b1;
            spec_val_s1 = {sa & sb, 15'd0};
        end else if (a_zero) begin
            spec_s1     = 1'b1;
            spec_val_s1 = B_59;
        end else if (b_zero) begin
            spec_s1     = 1'b1;
            spec_val_s1 = A_59;
        end
    end

    logic              vld_p0, sign_p0, sub_p0, spec_p0;
    logic [4:0]        exp_p0, diff_p0;
    logic [10:0]       man_l_p0, man_s_p0;
    logic [DATA_W-1:0] spec_val_p0;

    always_ff @(posedge clk_59 or negedge rst_59) begin
        if (!rst_59) begin
            vld_p0      <= 1'b0;
            sign_p0     <= 1'b0;
            sub_p0      <= 1'b0;
            spec_p0     <= 1'b0;
            exp_p0      <= '0;
            diff_p0     <= '0;
            man_l_p0    <= '0;
            man_s_p0    <= '0;
            spec_val_p0 <= '0;
        end else begin
            vld_p0      <= 1'b1;
            sign_p0     <= swap ? sb : sa;
            sub_p0      <= sa ^ sb;
            spec_p0     <= spec_s1;
            spec_val_p0 <= spec_val_s1;
            exp_p0      <= swap ? eb : ea;
            diff_p0     <= swap ? (eb - ea) : (ea - eb);
            man_l_p0    <= swap ? {1'b1, fb} : {1'b1, fa};
            man_s_p0    <= swap ? {1'b1, fa} : {1'b1, fb};
        end
    end

    // ---------------- stage 2: align smaller operand ----------------
    logic              vld_p1, sign_p1, sub_p1, spec_p1;
    logic [4:0]        exp_p1;
    logic [13:0]       mag_l_p1, mag_s_p1;
    logic [DATA_W-1:0] spec_val_p1;

    always_ff @(posedge clk_59 or negedge rst_59) begin
        if (!rst_59) begin
            vld_p1      <= 1'b0;
            sign_p1     <= 1'b0;
            sub_p1      <= 1'b0;
            spec_p1     <= 1'b0;
            exp_p1      <= '0;
            mag_l_p1    <= '0;
            mag_s_p1    <= '0;
            spec_val_p1 <= '0;
        end else begin
            vld_p1      <= vld_p0;
            sign_p1     <= sign_p0;
            sub_p1      <= sub_p0;
            spec_p1     <= spec_p0;
            exp_p1      <= exp_p0;
            mag_l_p1    <= {man_l_p0, 3'b000};
            mag_s_p1    <= align_sticky(man_s_p0, diff_p0);
            spec_val_p1 <= spec_val_p0;
        end
    end

    // ---------------- stage 3: add / subtract magnitudes ----------------
    logic              vld_p2, sign_p2, spec_p2;
    logic [4:0]        exp_p2;
    logic [14:0]       sum_p2;
    logic [DATA_W-1:0] spec_val_p2;

    always_ff @(posedge clk_59 or negedge rst_59) begin
        if (!rst_59) begin
            vld_p2      <= 1'b0;
            sign_p2     <= 1'b0;
            spec_p2     <= 1'b0;
            exp_p2      <= '0;
            sum_p2      <= '0;
            spec_val_p2 <= '0;
        end else begin
            vld_p2      <= vld_p1;
            sign_p2     <= sign_p1;
            spec_p2     <= spec_p1;
            exp_p2      <= exp_p1;
            // The larger magnitude is always on the left, so no borrow.
            sum_p2      <= sub_p1 ? ({1'b0, mag_l_p1} - {1'b0, mag_s_p1})
                                  : ({1'b0, mag_l_p1} + {1'b0, mag_s_p1});
            spec_val_p2 <= spec_val_p1;
        end
    end

    // ---------------- stage 4: normalize, round, pack ----------------
    logic [3:0]        lz_s4;
    logic [13:0]       norm_s4;
    logic signed [6:0] exp_s4;
    logic [DATA_W-1:0] res_s4;

    always_comb begin
        lz_s4   = '0;
        norm_s4 = '0;
        exp_s4  = '0;
        if (sum_p2[14]) begin
            norm_s4 = {sum_p2[14:2], sum_p2[1] | sum_p2[0]};
            exp_s4  = $signed({2'b00, exp_p2}) + 7'sd1;
        end else begin
            lz_s4   = lzc14(sum_p2[13:0]);
            norm_s4 = sum_p2[13:0] << lz_s4;
            exp_s4  = $signed({2'b00, exp_p2}) - $signed({3'b000, lz_s4});
        end
    end

    always_comb begin
        res_s4 = '0;
        if (spec_p2) begin
            res_s4 = spec_val_p2;
        end else if (sum_p2 == 15'd0) begin
            res_s4 = 16'h0000;
        end else begin
            res_s4 = pack_sat(sign_p2, exp_s4, round_man(norm_s4));
        end
    end

    always_ff @(posedge clk_59 or negedge rst_59) begin
        if (!rst_59) begin
            C_59 <= '0;
        end else begin
            C_59 <= vld_p2 ? res_s4 : 16'h0000;
        end
    end

endmodule

// File: tb/tb_fp_adder.sv
// tb_fp_adder -- directed self-checking bench for fp_adder.
// Inputs change on the falling clock edge; C_59 is read 1 time unit after
// the rising edge.
module tb_fp_adder;
    logic        clk_59 = 1'b0;
    logic        rst_59;
    logic [15:0] A_59;
    logic [15:0] B_59;
    logic [15:0] C_59;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk_59 = ~clk_59;

    fp_adder dut (
        .clk_59 (clk_59),
        .rst_59 (rst_59),
        .A_59   (A_59),
        .B_59   (B_59),
        .C_59   (C_59)
    );

    // Drive one pair, let it be sampled, return C_59 three edges later.
    task automatic issue(input logic [15:0] a, input logic [15:0] b,
                         output logic [15:0] obs);
        @(negedge clk_59);
        A_59 = a;
        B_59 = b;
        @(posedge clk_59);
        repeat (3) @(posedge clk_59);
        #1;
        obs = C_59;
    endtask

    task automatic test_reset();
        logic [15:0] obs;
        rst_59 = 1'b1;
        A_59   = 16'h3C00;
        B_59   = 16'h3C00;
        #2 rst_59 = 1'b0;
        #1;
        n_tests++;
        if (C_59 !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_async: C_59=%h expected %h", C_59, 16'h0000);
        end
        repeat (2) @(posedge clk_59);
        #1;
        n_tests++;
        if (C_59 !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_hold: C_59=%h expected %h", C_59, 16'h0000);
        end
        @(negedge clk_59);
        A_59   = 16'h5620;
        B_59   = 16'h5948;
        rst_59 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk_59);
            #1;
            n_tests++;
            if (C_59 !== 16'h0000) begin
                n_fail++;
                $display("FAIL latency_early_%0d: C_59=%h expected %h", i, C_59, 16'h0000);
            end
        end
        @(posedge clk_59);
        #1;
        obs = C_59;
        n_tests++;
        if (obs !== 16'h5C2C) begin
            n_fail++;
            $display("FAIL first_add: C_59=%h expected %h", obs, 16'h5C2C);
        end
    endtask

    task automatic test_sub();
        logic [15:0] obs;
        issue(16'h5630, 16'hD590, obs);
        n_tests++;
        if (obs !== 16'h4900) begin
            n_fail++;
            $display("FAIL sub_lshift: C_59=%h expected %h", obs, 16'h4900);
        end
        issue(16'hD1A0, 16'h54F0, obs);
        n_tests++;
        if (obs !== 16'h5040) begin
            n_fail++;
            $display("FAIL sub_swap: C_59=%h expected %h", obs, 16'h5040);
        end
        issue(16'hDC6C, 16'hD420, obs);
        n_tests++;
        if (obs !== 16'hDD74) begin
            n_fail++;
            $display("FAIL add_neg: C_59=%h expected %h", obs, 16'hDD74);
        end
    endtask

    task automatic test_zero();
        logic [15:0] obs;
        issue(16'h0000, 16'h0000, obs);
        n_tests++;
        if (obs !== 16'h0000) begin
            n_fail++;
            $display("FAIL zero_zero: C_59=%h expected %h", obs, 16'h0000);
        end
        issue(16'h8000, 16'h8000, obs);
        n_tests++;
        if (obs !== 16'h8000) begin
            n_fail++;
            $display("FAIL negzero_negzero: C_59=%h expected %h", obs, 16'h8000);
        end
        issue(16'h8000, 16'h0000, obs);
        n_tests++;
        if (obs !== 16'h0000) begin
            n_fail++;
            $display("FAIL negzero_poszero: C_59=%h expected %h", obs, 16'h0000);
        end
        issue(16'h0000, 16'hD750, obs);
        n_tests++;
        if (obs !== 16'hD750) begin
            n_fail++;
            $display("FAIL zero_pass: C_59=%h expected %h", obs, 16'hD750);
        end
        issue(16'h0001, 16'h3C00, obs);
        n_tests++;
        if (obs !== 16'h3C00) begin
            n_fail++;
            $display("FAIL subnormal_in: C_59=%h expected %h", obs, 16'h3C00);
        end
        issue(16'h3C00, 16'hBC00, obs);
        n_tests++;
        if (obs !== 16'h0000) begin
            n_fail++;
            $display("FAIL cancel: C_59=%h expected %h", obs, 16'h0000);
        end
        issue(16'h8401, 16'h0400, obs);
        n_tests++;
        if (obs !== 16'h8000) begin
            n_fail++;
            $display("FAIL underflow_flush: C_59=%h expected %h", obs, 16'h8000);
        end
    endtask

    task automatic test_special();
        logic [15:0] obs;
        issue(16'h7BFF, 16'h7BFF, obs);
        n_tests++;
        if (obs !== 16'h7C00) begin
            n_fail++;
            $display("FAIL overflow_inf: C_59=%h expected %h", obs, 16'h7C00);
        end
        issue(16'h7C00, 16'hFC00, obs);
        n_tests++;
        if (obs !== 16'h7E00) begin
            n_fail++;
            $display("FAIL inf_minus_inf: C_59=%h expected %h", obs, 16'h7E00);
        end
        issue(16'h7C01, 16'h3C00, obs);
        n_tests++;
        if (obs !== 16'h7E00) begin
            n_fail++;
            $display("FAIL nan_in: C_59=%h expected %h", obs, 16'h7E00);
        end
        issue(16'hFC00, 16'h3C00, obs);
        n_tests++;
        if (obs !== 16'hFC00) begin
            n_fail++;
            $display("FAIL inf_finite: C_59=%h expected %h", obs, 16'hFC00);
        end
        issue(16'h7C00, 16'h7C00, obs);
        n_tests++;
        if (obs !== 16'h7C00) begin
            n_fail++;
            $display("FAIL inf_inf_same: C_59=%h expected %h", obs, 16'h7C00);
        end
    endtask

    task automatic test_rounding();
        logic [15:0] obs;
        logic [15:0] expv;
        // 1.0009765625 + 0.50048828125 lies exactly halfway between
        // 0x3E01 and 0x3E02.
`ifdef FPADD_RNE_EN
        expv = 16'h3E02;
`else
        expv = 16'h3E01;
`endif
        issue(16'h3C01, 16'h3801, obs);
        n_tests++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL round_tie: C_59=%h expected %h", obs, expv);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] av [6];
        logic [15:0] bv [6];
        logic [15:0] ev [6];
        av = '{16'h5620, 16'h5630, 16'hD1A0, 16'hDC6C, 16'h7BFF, 16'h3C00};
        bv = '{16'h5948, 16'hD590, 16'h54F0, 16'hD420, 16'h7BFF, 16'hBC00};
        ev = '{16'h5C2C, 16'h4900, 16'h5040, 16'hDD74, 16'h7C00, 16'h0000};
        for (int k = 0; k < 9; k++) begin
            @(negedge clk_59);
            A_59 = (k < 6) ? av[k] : 16'h0000;
            B_59 = (k < 6) ? bv[k] : 16'h0000;
            @(posedge clk_59);
            #1;
            if (k >= 3) begin
                n_tests++;
                if (C_59 !== ev[k-3]) begin
                    n_fail++;
                    $display("FAIL b2b_%0d: C_59=%h expected %h", k - 3, C_59, ev[k-3]);
                end
            end
        end
    endtask

    task automatic test_reset_midstream();
        logic [15:0] av [5];
        logic [15:0] bv [5];
        av = '{16'h5620, 16'h5630, 16'hD1A0, 16'hDC6C, 16'h7BFF};
        bv = '{16'h5948, 16'hD590, 16'h54F0, 16'hD420, 16'h7BFF};
        for (int k = 0; k < 5; k++) begin
            @(negedge clk_59);
            A_59 = av[k];
            B_59 = bv[k];
            @(posedge clk_59);
        end
        #1;
        n_tests++;
        if (C_59 !== 16'h4900) begin
            n_fail++;
            $display("FAIL midstream_pre: C_59=%h expected %h", C_59, 16'h4900);
        end
        #1 rst_59 = 1'b0;
        #1;
        n_tests++;
        if (C_59 !== 16'h0000) begin
            n_fail++;
            $display("FAIL midstream_async: C_59=%h expected %h", C_59, 16'h0000);
        end
        @(negedge clk_59);
        A_59   = 16'h0000;
        B_59   = 16'h0000;
        rst_59 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk_59);
            #1;
            n_tests++;
            if (C_59 !== 16'h0000) begin
                n_fail++;
                $display("FAIL midstream_stale_%0d: C_59=%h expected %h", i, C_59, 16'h0000);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, failures so far %0d", n_fail);
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_sub();
        test_zero();
        test_special();
        test_rounding();
        test_back_to_back();
        test_reset_midstream();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
